emisor: RTL and testbench
=========================

# emisor

Serial transmitter that is the counterpart of the shift-register receiver (`receptor`). It takes a parallel word and sends it MSB-first on `signal_out`, one bit per clock. It holds `enable_out` high for the whole frame, and `enable_out` drives the receiver's `enable` directly. After each frame it holds `enable_out` low for a guard gap so the receiver can dump its shift register to `output_reg` before the next frame starts.

## Interface
- `SIZESREG`, 16: maximum frame length in bits; must match the receiver's `SIZESREG`.
- `GAP_CYCLES`, 2: idle cycles (`enable_out`=0) forced after every frame; minimum 1.
- `LENW`, `$clog2(SIZESREG+1)`: width of `nbits`.

Ports:
- `CLK`  in  1  single clock; all logic on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `start`  in  1  frame request; accepted only when `ready`=1.
- `data_in`  in  SIZESREG  word to send; sampled on the accept edge.
- `nbits`  in  LENW  frame length, sampled on the accept edge. 0 or >SIZESREG means SIZESREG.
- `ready`  out  1  high in IDLE only.
- `signal_out`  out  1  serial data; goes to the receiver's `signal_in`.
- `enable_out`  out  1  frame valid; goes to the receiver's `enable`.
- `done`  out  1  one-cycle pulse in the first GAP cycle.

## Operation
- States and transitions:
  - IDLE: `ready`=1; `start` moves to SHIFT.
  - SHIFT: runs for L cycles, then moves to GAP.
  - GAP: runs for `GAP_CYCLES` cycles, then moves to IDLE.
- Accept edge (IDLE, `start`=1, `RST`=0):
  - L = effective `nbits`.
  - Load shreg = `data_in` << (SIZESREG−L).
  - Clear the bit counter.
  - Registered outputs: `enable_out`<=1, `signal_out`<=`data_in[L-1]`.
- SHIFT:
  - Each edge shifts shreg left by one and drives the new MSB to `signal_out`.
  - The counter increments on each of these edges.
  - When L bits have been presented, the next edge enters GAP: `enable_out`<=0, `signal_out`<=0, `done`<=1.
- Bits go out as `data_in[L-1]` down to `data_in[0]`. A receiver shifting left therefore ends with `data_in[L-1:0]` in the low L bits of `output_reg`.
- GAP:
  - `done` is high for the first cycle only.
  - The gap counter counts `GAP_CYCLES` cycles, then returns to IDLE.
- `start` outside IDLE is ignored and not queued. `data_in` and `nbits` are don't-care outside the accept edge.
- `RST` has priority over everything, including `start` on the same edge. `RST` mid-frame aborts the frame with no `done` pulse. The receiver then sees a truncated frame; that is the expected behaviour.
- Reset values: state=IDLE, `ready`=1, `signal_out`=0, `enable_out`=0, `done`=0, shreg=0, counters=0.
- Arithmetic:
  - Bit counter width is LENW and compares against L.
  - Gap counter width is `$clog2(GAP_CYCLES+1)`.
  - No wrap-around is reachable, because both counters reset on state entry.

## Timing
- Latency from the accept edge to the first bit on `signal_out`: 1 cycle; all outputs are registered.
- `enable_out` is high for exactly L consecutive cycles, with exactly one bit per cycle.
- The receiver samples `signal_in` on the same edges. With `CLK` period 10 ns, bit k is valid from 10·k ns to 10·(k+1) ns after the accept edge.
- `ready` is low from the cycle after accept until the end of the last GAP cycle. The minimum frame-to-frame period is L + `GAP_CYCLES` + 1 cycles.
- `ready` is combinational from state; `start` must not depend combinationally on `ready`.

## Test plan
- Reset, hold `start`=1 with `RST`=1 for 3 cycles:
  - Required: `ready`=1, `enable_out`=0, `signal_out`=0 throughout.
  - Required: a frame starts only on the first edge after `RST` falls.
- Full frame, `data_in`=16'hA5C3, `nbits`=0:
  - Required: `enable_out` high for 16 cycles; `signal_out` = 1010 0101 1100 0011.
  - Required: `done` pulses 1 cycle after the last bit.
  - Required: a `receptor` instance in the same bench shows `output_reg`=16'hA5C3.
- Short frame, `data_in`=16'hFF55, `nbits`=8:
  - Required: 8 bits 01010101, then GAP.
  - Required: the receiver's low byte = 8'h55.
- Back-to-back, `start` held high with `GAP_CYCLES`=2:
  - Required: two frames separated by exactly 2 cycles of `enable_out`=0 and 1 IDLE cycle.
  - Required: the second word is sampled at its own accept edge.
- `start` pulsed mid-frame and during GAP:
  - Required: ignored; no extra frame.
  - Required: the `done` count equals the number of accepted frames.
- `RST` asserted at bit 5 of a 16-bit frame:
  - Required: next edge `enable_out`=0, `signal_out`=0, no `done`, `ready`=1 after `RST` is released.
- `nbits`=20 with SIZESREG=16:
  - Required: treated as 16; a 16-cycle frame is sent.

Source files
------------

// File: rtl/emisor.sv
`default_nettype none
// ============================================================================
// Module      : emisor
// Description : Serial frame transmitter. It accepts a parallel word and a
//               frame length L, then shifts the low L bits out MSB-first on
//               signal_out, one bit per clock, with enable_out high for the
//               whole frame. After each frame enable_out is held low for
//               GAP_CYCLES cycles so that the paired shift-register receiver
//               can move its contents to its output register.
//
// Ports       :
//   CLK        in   1         clock, rising edge
//   RST        in   1         synchronous active-high reset
//   start      in   1         frame request, honoured only while ready=1
//   data_in    in   SIZESREG  word to send, sampled on the accept edge
//   nbits      in   LENW      frame length; 0 or >SIZESREG means SIZESREG
//   ready      out  1         high while idle (decoded from state)
//   signal_out out  1         serial data, registered
//   enable_out out  1         frame-valid, registered
//   done       out  1         one-cycle pulse in the first gap cycle
//
// Revision    : 1.0 - initial release
// ============================================================================
module emisor #(
  parameter int SIZESREG   = 16,
  parameter int GAP_CYCLES = 2,
  parameter int LENW       = $clog2(SIZESREG + 1)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic [SIZESREG-1:0] data_in,
  input  logic [LENW-1:0]     nbits,
  output logic                ready,
  output logic                signal_out,
  output logic                enable_out,
  output logic                done
);

  // A gap shorter than one cycle would let the receiver miss the falling
  // edge of enable, so the counter is sized for at least one gap cycle.
  localparam int              GAP_EFF  = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int              GCW      = (GAP_EFF < 2) ? 1 : $clog2(GAP_EFF + 1);
  localparam logic [LENW-1:0] MAX_LEN  = LENW'(SIZESREG);
  localparam logic [GCW-1:0]  GAP_LAST = GCW'(GAP_EFF - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SIZESREG-1:0]  shreg_q, shreg_d;
  logic [LENW-1:0]      len_q, len_d;
  logic [LENW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [GCW-1:0]       gap_cnt_q, gap_cnt_d;
  logic                 signal_out_q, signal_out_d;
  logic                 enable_out_q, enable_out_d;
  logic                 done_q, done_d;

  logic [LENW-1:0]      eff_len;
  logic [LENW-1:0]      shift_amt;
  logic [SIZESREG-1:0]  load_word;
  logic [SIZESREG-1:0]  shreg_shl;
  logic                 last_bit;

  // Out-of-range lengths fall back to a full-width frame.
  always_comb begin
    eff_len = nbits;
    if ((nbits == '0) || (nbits > MAX_LEN)) begin
      eff_len = MAX_LEN;
    end
  end

  // Left-justify the word so that data_in[L-1] sits in the MSB; every
  // following bit then comes out of the same MSB position.
  assign shift_amt = MAX_LEN - eff_len;
  assign load_word = data_in << shift_amt;
  assign shreg_shl = shreg_q << 1;

  // bit_cnt counts bits already shifted past the first one, so the L-th bit
  // is on the line when it equals L-1.
  assign last_bit  = (bit_cnt_q == (len_q - LENW'(1)));

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    len_d        = len_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    signal_out_d = signal_out_q;
    enable_out_d = enable_out_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_SHIFT;
          len_d        = eff_len;
          shreg_d      = load_word;
          bit_cnt_d    = '0;
          enable_out_d = 1'b1;
          signal_out_d = load_word[SIZESREG-1];
        end
      end

      S_SHIFT: begin
        if (last_bit) begin
          state_d      = S_GAP;
          gap_cnt_d    = '0;
          shreg_d      = '0;
          enable_out_d = 1'b0;
          signal_out_d = 1'b0;
          done_d       = 1'b1;
        end else begin
          shreg_d      = shreg_shl;
          signal_out_d = shreg_shl[SIZESREG-1];
          bit_cnt_d    = bit_cnt_q + LENW'(1);
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GCW'(1);
        end
      end

      default: begin
        state_d      = S_IDLE;
        enable_out_d = 1'b0;
        signal_out_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      len_q        <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      signal_out_q <= 1'b0;
      enable_out_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      len_q        <= len_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      signal_out_q <= signal_out_d;
      enable_out_q <= enable_out_d;
      done_q       <= done_d;
    end
  end

  assign ready      = (state_q == S_IDLE);
  assign signal_out = signal_out_q;
  assign enable_out = enable_out_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_emisor.sv
`default_nettype none
// ============================================================================
// Module      : tb_emisor
// Description : Directed self-checking bench for emisor, with a behavioural
//               left-shifting receiver attached to signal_out/enable_out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_emisor;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [15:0] data_in;
  logic [4:0]  nbits;
  logic        ready;
  logic        signal_out;
  logic        enable_out;
  logic        done;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;

  // receiver model: shifts left while enable is high, dumps when it falls
  logic [15:0] rx_sh;
  logic [15:0] rx_out;
  logic        rx_en_q;

  emisor #(
    .SIZESREG   (16),
    .GAP_CYCLES (2),
    .LENW       (5)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .data_in    (data_in),
    .nbits      (nbits),
    .ready      (ready),
    .signal_out (signal_out),
    .enable_out (enable_out),
    .done       (done)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (RST) begin
      rx_sh   <= 16'h0;
      rx_out  <= 16'h0;
      rx_en_q <= 1'b0;
    end else begin
      rx_en_q <= enable_out;
      if (enable_out) begin
        rx_sh <= {rx_sh[14:0], signal_out};
      end else if (rx_en_q) begin
        rx_out <= rx_sh;
        rx_sh  <= 16'h0;
      end
    end
  end

  always @(posedge CLK) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // Bounded wait for the idle state; reports whether it was reached.
  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    bit ok;
    RST = 1'b1; start = 1'b1; data_in = 16'hFFFF; nbits = 5'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      n_vec++;
      if (ready !== 1'b1 || enable_out !== 1'b0 || signal_out !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold cyc%0d: ready=%b en=%b sig=%b, want 1 0 0", c, ready, enable_out, signal_out);
      end
    end
    data_in = 16'h8001;
    RST = 1'b0;
    @(negedge CLK);
    start = 1'b0;
    n_vec++;
    if (enable_out !== 1'b1 || signal_out !== 1'b1 || ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: en=%b sig=%b ready=%b, want 1 1 0", enable_out, signal_out, ready);
    end
    wait_idle(ok);
    n_vec++;
    if (!ok || rx_out !== 16'h8001) begin
      n_err++;
      $display("FAIL reset_frame: idle=%b rx=%h, want 1 8001", ok, rx_out);
    end
  endtask

  task automatic test_frame(input string name, input logic [15:0] d, input logic [4:0] nb,
                            input int len, input logic [15:0] exp_rx);
    logic exp_bit;
    int   c0;
    c0 = done_cnt;
    start = 1'b1; data_in = d; nbits = nb;
    @(negedge CLK);
    start = 1'b0; data_in = 16'h0; nbits = 5'd3;
    for (int i = 0; i < len; i++) begin
      exp_bit = d[len-1-i];
      n_vec++;
      if (enable_out !== 1'b1 || signal_out !== exp_bit || done !== 1'b0 || ready !== 1'b0) begin
        n_err++;
        $display("FAIL %s bit%0d: en=%b sig=%b done=%b ready=%b, want 1 %b 0 0",
                 name, i, enable_out, signal_out, done, ready, exp_bit);
      end
      @(negedge CLK);
    end
    n_vec++;
    if (enable_out !== 1'b0 || signal_out !== 1'b0 || done !== 1'b1) begin
      n_err++;
      $display("FAIL %s gap1: en=%b sig=%b done=%b, want 0 0 1", name, enable_out, signal_out, done);
    end
    @(negedge CLK);
    n_vec++;
    if (enable_out !== 1'b0 || done !== 1'b0 || ready !== 1'b0 || rx_out !== exp_rx) begin
      n_err++;
      $display("FAIL %s gap2: en=%b done=%b ready=%b rx=%h, want 0 0 0 %h",
               name, enable_out, done, ready, rx_out, exp_rx);
    end
    @(negedge CLK);
    n_vec++;
    if (ready !== 1'b1 || enable_out !== 1'b0 || (done_cnt - c0) != 1) begin
      n_err++;
      $display("FAIL %s idle: ready=%b en=%b dones=%0d, want 1 0 1", name, ready, enable_out, done_cnt - c0);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp_en;
    logic [10:0] exp_sig;
    logic [10:0] exp_rdy;
    bit ok;
    int c0;
    exp_en  = 11'b1111_000_1111;
    exp_sig = 11'b1010_000_0101;
    exp_rdy = 11'b0000_001_0000;
    c0 = done_cnt;
    start = 1'b1; data_in = 16'h000A; nbits = 5'd4;
    @(negedge CLK);
    data_in = 16'h0005;
    for (int i = 0; i < 11; i++) begin
      n_vec++;
      if (enable_out !== exp_en[10-i] || signal_out !== exp_sig[10-i] || ready !== exp_rdy[10-i]) begin
        n_err++;
        $display("FAIL b2b cyc%0d: en=%b sig=%b ready=%b, want %b %b %b",
                 i, enable_out, signal_out, ready, exp_en[10-i], exp_sig[10-i], exp_rdy[10-i]);
      end
      @(negedge CLK);
    end
    start = 1'b0;
    wait_idle(ok);
    n_vec++;
    if (!ok || rx_out !== 16'h0005 || (done_cnt - c0) != 2) begin
      n_err++;
      $display("FAIL b2b end: idle=%b rx=%h dones=%0d, want 1 0005 2", ok, rx_out, done_cnt - c0);
    end
  endtask

  task automatic test_ignore_start();
    int c0;
    int extra_en;
    c0 = done_cnt;
    start = 1'b1; data_in = 16'h002D; nbits = 5'd6;
    @(negedge CLK);
    start = 1'b0;
    repeat (2) @(negedge CLK);
    start = 1'b1; data_in = 16'hFFFF; nbits = 5'd0;
    @(negedge CLK);
    start = 1'b0;
    repeat (3) @(negedge CLK);
    n_vec++;
    if (done !== 1'b1 || enable_out !== 1'b0) begin
      n_err++;
      $display("FAIL ignore gap1: done=%b en=%b, want 1 0", done, enable_out);
    end
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    n_vec++;
    if (ready !== 1'b1) begin
      n_err++;
      $display("FAIL ignore idle: ready=%b, want 1", ready);
    end
    extra_en = 0;
    for (int k = 0; k < 4; k++) begin
      if (enable_out !== 1'b0) extra_en++;
      @(negedge CLK);
    end
    n_vec++;
    if (extra_en != 0 || (done_cnt - c0) != 1 || rx_out !== 16'h002D) begin
      n_err++;
      $display("FAIL ignore result: extra_en=%0d dones=%0d rx=%h, want 0 1 002d", extra_en, done_cnt - c0, rx_out);
    end
  endtask

  task automatic test_rst_abort();
    int c0;
    c0 = done_cnt;
    start = 1'b1; data_in = 16'hFFFF; nbits = 5'd0;
    @(negedge CLK);
    start = 1'b0;
    repeat (5) @(negedge CLK);
    n_vec++;
    if (enable_out !== 1'b1 || signal_out !== 1'b1) begin
      n_err++;
      $display("FAIL abort bit5: en=%b sig=%b, want 1 1", enable_out, signal_out);
    end
    RST = 1'b1;
    @(negedge CLK);
    n_vec++;
    if (enable_out !== 1'b0 || signal_out !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL abort edge: en=%b sig=%b done=%b, want 0 0 0", enable_out, signal_out, done);
    end
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    n_vec++;
    if (ready !== 1'b1 || enable_out !== 1'b0 || (done_cnt - c0) != 0) begin
      n_err++;
      $display("FAIL abort after: ready=%b en=%b dones=%0d, want 1 0 0", ready, enable_out, done_cnt - c0);
    end
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; data_in = 16'h0; nbits = 5'd0;
    test_reset();
    test_frame("full_a5c3", 16'hA5C3, 5'd0, 16, 16'hA5C3);
    test_frame("short_ff55", 16'hFF55, 5'd8, 8, 16'h0055);
    test_frame("nbits20", 16'h1234, 5'd20, 16, 16'h1234);
    test_frame("nbits1", 16'hFFFE, 5'd1, 1, 16'h0000);
    test_back_to_back();
    test_ignore_start();
    test_rst_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
